// File: rtl/rs_age_queue.sv
// rs_age_queue: reservation station with multi-port CDB wakeup, insert bypass
// and oldest-ready dispatch selected through an age matrix.
module rs_age_queue #(
  parameter int DEPTH   = 16,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 4,
  parameter int OP_W    = 6,
  parameter int NUM_CDB = 2,
  parameter int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OP_W-1:0]           in_op,
  input  logic [TAG_W-1:0]          in_rob,
  input  logic                      in_q1_rdy,
  input  logic [TAG_W-1:0]          in_q1_tag,
  input  logic [DATA_W-1:0]         in_v1,
  input  logic                      in_q2_rdy,
  input  logic [TAG_W-1:0]          in_q2_tag,
  input  logic [DATA_W-1:0]         in_v2,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
  output logic                      issue_valid,
  input  logic                      issue_ready,
  output logic [OP_W-1:0]           issue_op,
  output logic [DATA_W-1:0]         issue_v1,
  output logic [DATA_W-1:0]         issue_v2,
  output logic [TAG_W-1:0]          issue_rob,
  output logic [CNT_W-1:0]          count,
  output logic                      almost_full
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(DEPTH - 1);

  // Returns {hit, data}; scanning downward lets the lowest matching port win.
  function automatic logic [DATA_W:0] cdb_lookup(
    input logic [TAG_W-1:0]          tag,
    input logic [NUM_CDB-1:0]        vld,
    input logic [NUM_CDB*TAG_W-1:0]  tags,
    input logic [NUM_CDB*DATA_W-1:0] data
  );
    logic [DATA_W:0] res;
    res = '0;
    for (int p = NUM_CDB - 1; p >= 0; p--) begin
      if (vld[p] && (tags[p*TAG_W +: TAG_W] == tag)) begin
        res = {1'b1, data[p*DATA_W +: DATA_W]};
      end
    end
    return res;
  endfunction

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  r1_q, r1_d, r2_q, r2_d;
  logic [OP_W-1:0]   op_q  [DEPTH];
  logic [OP_W-1:0]   op_d  [DEPTH];
  logic [TAG_W-1:0]  rob_q [DEPTH];
  logic [TAG_W-1:0]  rob_d [DEPTH];
  logic [TAG_W-1:0]  t1_q  [DEPTH];
  logic [TAG_W-1:0]  t1_d  [DEPTH];
  logic [TAG_W-1:0]  t2_q  [DEPTH];
  logic [TAG_W-1:0]  t2_d  [DEPTH];
  logic [DATA_W-1:0] v1_q  [DEPTH];
  logic [DATA_W-1:0] v1_d  [DEPTH];
  logic [DATA_W-1:0] v2_q  [DEPTH];
  logic [DATA_W-1:0] v2_d  [DEPTH];
  logic [DEPTH-1:0]  older_q [DEPTH];
  logic [DEPTH-1:0]  older_d [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic              in_ready_q, in_ready_d, af_q, af_d;
  logic              iv_q, iv_d;
  logic [OP_W-1:0]   iop_q, iop_d;
  logic [DATA_W-1:0] iv1_q, iv1_d, iv2_q, iv2_d;
  logic [TAG_W-1:0]  irob_q, irob_d;

  logic [DEPTH-1:0]  ready_ent, oldest;
  logic [IDX_W-1:0]  ins_idx, sel_idx;
  logic [DATA_W:0]   wk1 [DEPTH];
  logic [DATA_W:0]   wk2 [DEPTH];
  logic [DATA_W:0]   byp1, byp2;
  logic              do_ins, do_sel;

  // Oldest-ready select and lowest free slot, both from registered state only.
  always_comb begin
    ready_ent = valid_q & r1_q & r2_q;
    oldest    = '0;
    sel_idx   = '0;
    ins_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      oldest[k] = ready_ent[k];
      for (int j = 0; j < DEPTH; j++) begin
        if (ready_ent[j] && older_q[j][k]) oldest[k] = 1'b0;
      end
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (oldest[i])   sel_idx = IDX_W'(i);
      if (!valid_q[i]) ins_idx = IDX_W'(i);
    end
  end

  // CDB tag matches for every stored operand and for the incoming op.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wk1[i] = cdb_lookup(t1_q[i], cdb_valid, cdb_tag, cdb_data);
      wk2[i] = cdb_lookup(t2_q[i], cdb_valid, cdb_tag, cdb_data);
    end
    byp1 = cdb_lookup(in_q1_tag, cdb_valid, cdb_tag, cdb_data);
    byp2 = cdb_lookup(in_q2_tag, cdb_valid, cdb_tag, cdb_data);
  end

  assign do_sel = rdy_in && !clear && (!iv_q || issue_ready) && (|ready_ent);
  assign do_ins = rdy_in && !clear && in_valid && (count_q != FULL_CNT);

  // Next-state: flush, wakeup, dispatch, insert and occupancy.
  always_comb begin
    valid_d = valid_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    for (int i = 0; i < DEPTH; i++) begin
      op_d[i]    = op_q[i];
      rob_d[i]   = rob_q[i];
      t1_d[i]    = t1_q[i];
      t2_d[i]    = t2_q[i];
      v1_d[i]    = v1_q[i];
      v2_d[i]    = v2_q[i];
      older_d[i] = older_q[i];
    end
    count_d = count_q;
    iv_d    = iv_q;
    iop_d   = iop_q;
    iv1_d   = iv1_q;
    iv2_d   = iv2_q;
    irob_d  = irob_q;

    if (!rdy_in) begin
      iv_d = iv_q;
    end else if (clear) begin
      valid_d = '0;
      r1_d    = '0;
      r2_d    = '0;
      for (int i = 0; i < DEPTH; i++) older_d[i] = '0;
      count_d = '0;
      iv_d    = 1'b0;
      iop_d   = '0;
      iv1_d   = '0;
      iv2_d   = '0;
      irob_d  = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && !r1_q[i] && wk1[i][DATA_W]) begin
          r1_d[i] = 1'b1;
          v1_d[i] = wk1[i][DATA_W-1:0];
        end
        if (valid_q[i] && !r2_q[i] && wk2[i][DATA_W]) begin
          r2_d[i] = 1'b1;
          v2_d[i] = wk2[i][DATA_W-1:0];
        end
      end

      if (do_sel) begin
        iv_d    = 1'b1;
        iop_d   = op_q[sel_idx];
        iv1_d   = v1_q[sel_idx];
        iv2_d   = v2_q[sel_idx];
        irob_d  = rob_q[sel_idx];
        valid_d[sel_idx] = 1'b0;
        older_d[sel_idx] = '0;
        for (int j = 0; j < DEPTH; j++) older_d[j][sel_idx] = 1'b0;
      end else if (iv_q && issue_ready) begin
        iv_d = 1'b0;
      end else begin
        iv_d = iv_q;
      end

      if (do_ins) begin
        valid_d[ins_idx] = 1'b1;
        op_d[ins_idx]    = in_op;
        rob_d[ins_idx]   = in_rob;
        t1_d[ins_idx]    = in_q1_tag;
        t2_d[ins_idx]    = in_q2_tag;
        r1_d[ins_idx]    = in_q1_rdy | byp1[DATA_W];
        r2_d[ins_idx]    = in_q2_rdy | byp2[DATA_W];
        v1_d[ins_idx]    = (!in_q1_rdy && byp1[DATA_W]) ? byp1[DATA_W-1:0] : in_v1;
        v2_d[ins_idx]    = (!in_q2_rdy && byp2[DATA_W]) ? byp2[DATA_W-1:0] : in_v2;
        older_d[ins_idx] = '0;
        // Entry leaving this same edge must not be recorded as older.
        for (int j = 0; j < DEPTH; j++) begin
          older_d[j][ins_idx] = valid_q[j] && !(do_sel && (sel_idx == IDX_W'(j)));
        end
      end

      count_d = count_q + CNT_W'(do_ins) - CNT_W'(do_sel);
    end

    in_ready_d = (count_d != FULL_CNT);
    af_d       = (count_d >= AF_CNT);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]    <= '0;
        rob_q[i]   <= '0;
        t1_q[i]    <= '0;
        t2_q[i]    <= '0;
        v1_q[i]    <= '0;
        v2_q[i]    <= '0;
        older_q[i] <= '0;
      end
      count_q    <= '0;
      in_ready_q <= 1'b1;
      af_q       <= 1'b0;
      iv_q       <= 1'b0;
      iop_q      <= '0;
      iv1_q      <= '0;
      iv2_q      <= '0;
      irob_q     <= '0;
    end else begin
      valid_q <= valid_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]    <= op_d[i];
        rob_q[i]   <= rob_d[i];
        t1_q[i]    <= t1_d[i];
        t2_q[i]    <= t2_d[i];
        v1_q[i]    <= v1_d[i];
        v2_q[i]    <= v2_d[i];
        older_q[i] <= older_d[i];
      end
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      af_q       <= af_d;
      iv_q       <= iv_d;
      iop_q      <= iop_d;
      iv1_q      <= iv1_d;
      iv2_q      <= iv2_d;
      irob_q     <= irob_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign almost_full = af_q;
  assign count       = count_q;
  assign issue_valid = iv_q;
  assign issue_op    = iop_q;
  assign issue_v1    = iv1_q;
  assign issue_v2    = iv2_q;
  assign issue_rob   = irob_q;

endmodule

// File: tb/tb_rs_age_queue.sv
// Bench for rs_age_queue: directed scenarios plus randomized traffic compared
// against an age-ordered queue model of the reservation station.
module tb_rs_age_queue;
  localparam int DEPTH   = 16;
  localparam int DATA_W  = 32;
  localparam int TAG_W   = 4;
  localparam int OP_W    = 6;
  localparam int NUM_CDB = 2;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic                      clk_in = 1'b0;
  logic                      rst_in, rdy_in, clear, in_valid, in_ready;
  logic [OP_W-1:0]           in_op;
  logic [TAG_W-1:0]          in_rob, in_q1_tag, in_q2_tag;
  logic                      in_q1_rdy, in_q2_rdy;
  logic [DATA_W-1:0]         in_v1, in_v2;
  logic [NUM_CDB-1:0]        cdb_valid;
  logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
  logic [NUM_CDB*DATA_W-1:0] cdb_data;
  logic                      issue_valid, issue_ready;
  logic [OP_W-1:0]           issue_op;
  logic [DATA_W-1:0]         issue_v1, issue_v2;
  logic [TAG_W-1:0]          issue_rob;
  logic [CNT_W-1:0]          count;
  logic                      almost_full;

  always #5 clk_in = ~clk_in;

  rs_age_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W),
                 .NUM_CDB(NUM_CDB)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rob(in_rob),
    .in_q1_rdy(in_q1_rdy), .in_q1_tag(in_q1_tag), .in_v1(in_v1),
    .in_q2_rdy(in_q2_rdy), .in_q2_tag(in_q2_tag), .in_v2(in_v2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_v1(issue_v1), .issue_v2(issue_v2), .issue_rob(issue_rob),
    .count(count), .almost_full(almost_full)
  );

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  rob;
    logic              r1;
    logic [TAG_W-1:0]  t1;
    logic [DATA_W-1:0] v1;
    logic              r2;
    logic [TAG_W-1:0]  t2;
    logic [DATA_W-1:0] v2;
  } ent_t;

  ent_t mq[$];
  logic m_iv = 1'b0;
  ent_t m_pay;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_lookup(input logic [TAG_W-1:0] t, output logic [DATA_W-1:0] d);
    d = '0;
    for (int p = 0; p < NUM_CDB; p++) begin
      if (cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == t) begin
        d = cdb_data[p*DATA_W +: DATA_W];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // One clock of the reference: queue order is age order.
  task automatic model_step();
    ent_t e;
    logic [DATA_W-1:0] d;
    int sel;
    bit ins;
    if (rst_in) begin mq.delete(); m_iv = 1'b0; return; end
    if (!rdy_in) return;
    if (clear)  begin mq.delete(); m_iv = 1'b0; return; end
    ins = in_valid && (mq.size() < DEPTH);
    if (!m_iv || issue_ready) begin
      sel = -1;
      for (int i = 0; i < mq.size(); i++) begin
        if (mq[i].r1 && mq[i].r2) begin sel = i; break; end
      end
      if (sel >= 0) begin m_pay = mq[sel]; mq.delete(sel); m_iv = 1'b1; end
      else m_iv = 1'b0;
    end
    for (int i = 0; i < mq.size(); i++) begin
      if (!mq[i].r1 && m_lookup(mq[i].t1, d)) begin mq[i].r1 = 1'b1; mq[i].v1 = d; end
      if (!mq[i].r2 && m_lookup(mq[i].t2, d)) begin mq[i].r2 = 1'b1; mq[i].v2 = d; end
    end
    if (ins) begin
      e.op = in_op; e.rob = in_rob; e.t1 = in_q1_tag; e.t2 = in_q2_tag;
      e.r1 = in_q1_rdy; e.v1 = in_v1; e.r2 = in_q2_rdy; e.v2 = in_v2;
      if (!in_q1_rdy && m_lookup(in_q1_tag, d)) begin e.r1 = 1'b1; e.v1 = d; end
      if (!in_q2_rdy && m_lookup(in_q2_tag, d)) begin e.r2 = 1'b1; e.v2 = d; end
      mq.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_step();
    #1;
    check_eq("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
    check_eq("count", 64'(count), 64'(mq.size()));
    check_eq("almost_full", 64'(almost_full), 64'(mq.size() >= DEPTH - 1));
    check_eq("issue_valid", 64'(issue_valid), 64'(m_iv));
    if (m_iv) begin
      check_eq("issue_op", 64'(issue_op), 64'(m_pay.op));
      check_eq("issue_v1", 64'(issue_v1), 64'(m_pay.v1));
      check_eq("issue_v2", 64'(issue_v2), 64'(m_pay.v2));
      check_eq("issue_rob", 64'(issue_rob), 64'(m_pay.rob));
    end
  endtask

  task automatic idle();
    rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; in_valid = 1'b0;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
  endtask

  task automatic put(input logic [TAG_W-1:0] rob, input logic r1, input logic [TAG_W-1:0] t1,
                     input logic [DATA_W-1:0] v1, input logic r2, input logic [TAG_W-1:0] t2,
                     input logic [DATA_W-1:0] v2);
    in_valid = 1'b1; in_op = OP_W'($urandom); in_rob = rob;
    in_q1_rdy = r1; in_q1_tag = t1; in_v1 = v1;
    in_q2_rdy = r2; in_q2_tag = t2; in_v2 = v2;
  endtask

  initial begin
    idle();
    issue_ready = 1'b1;
    put(4'd0, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 32'd0);
    in_valid = 1'b0;
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
    check_eq("t1_reset_count", 64'(count), 64'd0);

    // T1: ready op appears on the issue port two edges after insertion.
    put(4'd3, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd7);
    tick();
    idle();
    tick();
    check_eq("t1_valid", 64'(issue_valid), 64'd1);
    check_eq("t1_v1", 64'(issue_v1), 64'd5);
    check_eq("t1_v2", 64'(issue_v2), 64'd7);
    check_eq("t1_rob", 64'(issue_rob), 64'd3);
    tick();

    // T2: two entries waiting on tag 9 leave in age order.
    put(4'd1, 1'b0, 4'd9, 32'd0, 1'b1, 4'd0, 32'd100);
    tick();
    put(4'd2, 1'b0, 4'd9, 32'd0, 1'b1, 4'd0, 32'd200);
    tick();
    idle();
    cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd9}; cdb_data = {32'd0, 32'd42};
    tick();
    idle();
    tick();
    check_eq("t2_first_rob", 64'(issue_rob), 64'd1);
    check_eq("t2_first_v1", 64'(issue_v1), 64'd42);
    tick();
    check_eq("t2_second_rob", 64'(issue_rob), 64'd2);
    tick();

    // T3: both operands captured from different CDB ports at insert.
    put(4'd5, 1'b0, 4'd4, 32'd0, 1'b0, 4'd6, 32'd0);
    cdb_valid = 2'b11; cdb_tag = {4'd6, 4'd4}; cdb_data = {32'd22, 32'd11};
    tick();
    idle();
    tick();
    check_eq("t3_valid", 64'(issue_valid), 64'd1);
    check_eq("t3_v1", 64'(issue_v1), 64'd11);
    check_eq("t3_v2", 64'(issue_v2), 64'd22);
    tick();

    // Same tag on both ports: port 0 data is taken.
    put(4'd6, 1'b0, 4'd8, 32'd0, 1'b1, 4'd0, 32'd1);
    cdb_valid = 2'b11; cdb_tag = {4'd8, 4'd8}; cdb_data = {32'd77, 32'd55};
    tick();
    idle();
    tick();
    check_eq("prio_v1", 64'(issue_v1), 64'd55);
    tick();

    // T4: fill to capacity with the ALU stalled, then dispatch while full.
    issue_ready = 1'b0;
    put(4'd0, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd2);
    tick();
    idle();
    tick();
    for (int i = 1; i < DEPTH; i++) begin
      put(TAG_W'(i), 1'b0, 4'd15, 32'd0, 1'b1, 4'd0, 32'(i));
      tick();
    end
    check_eq("t4_af15", 64'(almost_full), 64'd1);
    check_eq("t4_ready15", 64'(in_ready), 64'd1);
    put(4'd0, 1'b1, 4'd0, 32'd9, 1'b1, 4'd0, 32'd9);
    tick();
    check_eq("t4_full_ready", 64'(in_ready), 64'd0);
    check_eq("t4_full_count", 64'(count), 64'd16);
    issue_ready = 1'b1;
    put(4'd7, 1'b1, 4'd0, 32'd3, 1'b1, 4'd0, 32'd3);
    tick();
    // Extra insert dropped; one entry moved to the issue registers.
    check_eq("t4_drop_count", 64'(count), 64'd15);
    check_eq("t4_ready_again", 64'(in_ready), 64'd1);

    // T6: flush beats insert, dispatch and CDB; late wakeups find nothing.
    put(4'd8, 1'b1, 4'd0, 32'd3, 1'b1, 4'd0, 32'd3);
    clear = 1'b1;
    cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd15}; cdb_data = '0;
    tick();
    check_eq("t6_count", 64'(count), 64'd0);
    check_eq("t6_issue_valid", 64'(issue_valid), 64'd0);
    idle();
    cdb_valid = 2'b11; cdb_tag = {4'd15, 4'd15};
    tick();
    idle();
    tick();
    check_eq("t6_no_resurrect", 64'(issue_valid), 64'd0);

    // T5: ALU stall holds payload; release drains oldest first.
    issue_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      put(TAG_W'(i), 1'b1, 4'd0, 32'(10 * i), 1'b1, 4'd0, 32'(i));
      tick();
    end
    idle();
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t5_hold_rob", 64'(issue_rob), 64'd1);
      check_eq("t5_hold_count", 64'(count), 64'd3);
    end
    issue_ready = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      tick();
      check_eq("t5_drain_rob", 64'(issue_rob), 64'(i));
    end
    tick();
    check_eq("t5_drained", 64'(issue_valid), 64'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      rst_in      = ($urandom_range(0, 599) == 0);
      rdy_in      = ($urandom_range(0, 9) != 0);
      clear       = ($urandom_range(0, 149) == 0);
      issue_ready = ($urandom_range(0, 3) != 0);
      in_valid    = ($urandom_range(0, 1) == 1);
      in_op       = OP_W'($urandom);
      in_rob      = TAG_W'($urandom);
      in_q1_rdy   = ($urandom_range(0, 1) == 1);
      in_q2_rdy   = ($urandom_range(0, 1) == 1);
      in_q1_tag   = TAG_W'($urandom);
      in_q2_tag   = TAG_W'($urandom);
      in_v1       = $urandom;
      in_v2       = $urandom;
      for (int p = 0; p < NUM_CDB; p++) begin
        cdb_valid[p] = ($urandom_range(0, 9) < 4);
        cdb_tag[p*TAG_W +: TAG_W]   = TAG_W'($urandom);
        cdb_data[p*DATA_W +: DATA_W] = $urandom;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
